sid_access_arbiter: RTL and testbench

- Shares the single SID register port between the host CPU bus and a secondary write-only requester, such as the OSD/firmware tune player or a register-dump replayer.
- Sits in the clk32 domain, directly in front of the sid8580 cs/we/addr/data_in inputs.
- The CPU always has priority. Secondary writes are buffered in a FIFO and issued at most one per 1 MHz SID cycle, in idle bus slots.
- Paces writes so the voices see at most one register change per SID clock.

---
 rtl/sid_access_arbiter.sv | 272 +++++++++++++++++++++++++++
 tb/tb_sid_access_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_access_arbiter.sv
// rtl/sid_access_arbiter.sv - Shares the sid8580 register port between the CPU and a paced secondary writer
//
// The CPU always wins the port. Secondary writes are queued in a FIFO and issued
// one at a time on idle 1 MHz SID slots, at most one per MIN_GAP slot ticks.
// Every SID-side output is registered: one clk32 of latency from either requester.
//
// Optional build macro: SID_ARB_PANIC_EN
//   Adds a panic input. Shadows of the voice control registers (0x04, 0x0B, 0x12)
//   are kept, and a panic pulse flushes the queue and replays those registers with
//   the gate bit cleared on the next three eligible slots.
//
// Parameters:
//   FIFO_DEPTH  secondary FIFO entries (power of two, 2..64)
//   MIN_GAP     slot ticks between consecutive secondary writes (1..15)
//
// Ports:
//   clk32, reset               32 MHz clock, asynchronous active-high reset
//   slot_tick                  one-clk32 pulse per SID 1 MHz cycle
//   cpu_cs/we/addr/din         CPU register access
//   ext_valid/ready/addr/data  secondary write request handshake
//   ext_flush                  clears the pending secondary FIFO
//   panic                      (SID_ARB_PANIC_EN only) gate-off request pulse
//   sid_cs/we/addr/din         to sid8580 cs/we/addr/data_in
//   fifo_level                 FIFO occupancy
//   busy                       queue non-empty or a sequence in progress

module sid_access_arbiter #(
    parameter int FIFO_DEPTH = 16,
    parameter int MIN_GAP    = 1
) (
    input  logic                        clk32,
    input  logic                        reset,
    input  logic                        slot_tick,
    input  logic                        cpu_cs,
    input  logic                        cpu_we,
    input  logic [4:0]                  cpu_addr,
    input  logic [7:0]                  cpu_din,
    input  logic                        ext_valid,
    output logic                        ext_ready,
    input  logic [4:0]                  ext_addr,
    input  logic [7:0]                  ext_data,
    input  logic                        ext_flush,
`ifdef SID_ARB_PANIC_EN
    input  logic                        panic,
`endif
    output logic                        sid_cs,
    output logic                        sid_we,
    output logic [4:0]                  sid_addr,
    output logic [7:0]                  sid_din,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

`ifdef SID_ARB_PANIC_EN
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_ISSUE, S_PANIC0, S_PANIC1, S_PANIC2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_WAIT, S_ISSUE
    } state_t;
`endif

    state_t state, state_next;

    // FIFO storage and bookkeeping
    logic [4:0]    mem_addr [FIFO_DEPTH];
    logic [7:0]    mem_data [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count;
    logic          full, empty, flush, push, pop;

    logic [3:0]    gap, gap_after;
    logic          sec_go;
    logic          hold_off;

    logic          nxt_cs, nxt_we;
    logic [4:0]    nxt_addr;
    logic [7:0]    nxt_din;

`ifdef SID_ARB_PANIC_EN
    logic          panic_req, enter_panic, pan_go, in_panic;
    logic [7:0]    sh_04, sh_0b, sh_12;
    logic [4:0]    pan_addr;
    logic [7:0]    pan_din;

    assign in_panic  = (state == S_PANIC0) || (state == S_PANIC1) || (state == S_PANIC2);
    // A pending or running replay blocks new secondary work; the pulse itself flushes.
    assign hold_off  = panic_req;
    assign flush     = ext_flush || panic;
    assign ext_ready = !full && !ext_flush && !panic && !panic_req && !in_panic;
    assign busy      = (count != '0) || (state != S_IDLE) || panic_req;
`else
    assign hold_off  = 1'b0;
    assign flush     = ext_flush;
    assign ext_ready = !full && !ext_flush;
    assign busy      = (count != '0) || (state != S_IDLE);
`endif

    assign full       = (count == LW'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign push       = ext_valid && ext_ready;
    // The head stays in place until the ISSUE cycle; a flush in that cycle wins.
    assign pop        = (state == S_ISSUE) && !empty && !flush;
    assign fifo_level = count;

    always_ff @(posedge clk32) begin
        if (push) begin
            mem_addr[wr_ptr] <= ext_addr;
            mem_data[wr_ptr] <= ext_data;
        end
    end

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Gap counter: value after this cycle's tick decrement, saturating at zero.
    assign gap_after = (slot_tick && gap != 4'd0) ? gap - 4'd1 : gap;

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset)                 gap <= 4'd0;
        else if (state == S_ISSUE) gap <= 4'(MIN_GAP);
        else                       gap <= gap_after;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        sec_go     = 1'b0;
`ifdef SID_ARB_PANIC_EN
        enter_panic = 1'b0;
        pan_go      = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (hold_off) begin
`ifdef SID_ARB_PANIC_EN
                    enter_panic = 1'b1;
                    state_next  = S_PANIC0;
`endif
                end else if (!empty) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (hold_off) begin
`ifdef SID_ARB_PANIC_EN
                    enter_panic = 1'b1;
                    state_next  = S_PANIC0;
`endif
                end else if (empty) begin
                    state_next = S_IDLE;
                end else if (slot_tick && gap_after == 4'd0 && !cpu_cs) begin
                    sec_go     = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: state_next = S_IDLE;
`ifdef SID_ARB_PANIC_EN
            // Replay writes ignore MIN_GAP but still lose a slot to the CPU.
            S_PANIC0: if (slot_tick && !cpu_cs) begin pan_go = 1'b1; state_next = S_PANIC1; end
            S_PANIC1: if (slot_tick && !cpu_cs) begin pan_go = 1'b1; state_next = S_PANIC2; end
            S_PANIC2: if (slot_tick && !cpu_cs) begin pan_go = 1'b1; state_next = S_IDLE;   end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

`ifdef SID_ARB_PANIC_EN
    always_comb begin
        pan_addr = 5'h04;
        pan_din  = sh_04 & 8'hFE;
        if (state == S_PANIC1) begin
            pan_addr = 5'h0B;
            pan_din  = sh_0b & 8'hFE;
        end else if (state == S_PANIC2) begin
            pan_addr = 5'h12;
            pan_din  = sh_12 & 8'hFE;
        end
    end

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset)            panic_req <= 1'b0;
        else if (panic)       panic_req <= 1'b1;
        else if (enter_panic) panic_req <= 1'b0;
    end
`endif

    // Output selection: CPU first, then the queued write, otherwise idle with
    // address/data held.
    always_comb begin
        nxt_cs   = 1'b0;
        nxt_we   = 1'b0;
        nxt_addr = sid_addr;
        nxt_din  = sid_din;
        if (cpu_cs) begin
            nxt_cs   = 1'b1;
            nxt_we   = cpu_we;
            nxt_addr = cpu_addr;
            nxt_din  = cpu_din;
        end else if (sec_go) begin
            nxt_cs   = 1'b1;
            nxt_we   = 1'b1;
            nxt_addr = mem_addr[rd_ptr];
            nxt_din  = mem_data[rd_ptr];
`ifdef SID_ARB_PANIC_EN
        end else if (pan_go) begin
            nxt_cs   = 1'b1;
            nxt_we   = 1'b1;
            nxt_addr = pan_addr;
            nxt_din  = pan_din;
`endif
        end
    end

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            sid_cs   <= 1'b0;
            sid_we   <= 1'b0;
            sid_addr <= 5'd0;
            sid_din  <= 8'd0;
        end else begin
            sid_cs   <= nxt_cs;
            sid_we   <= nxt_we;
            sid_addr <= nxt_addr;
            sid_din  <= nxt_din;
        end
    end

`ifdef SID_ARB_PANIC_EN
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            sh_04 <= 8'd0;
            sh_0b <= 8'd0;
            sh_12 <= 8'd0;
        end else if (nxt_cs && nxt_we) begin
            case (nxt_addr)
                5'h04:   sh_04 <= nxt_din;
                5'h0B:   sh_0b <= nxt_din;
                5'h12:   sh_12 <= nxt_din;
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_sid_access_arbiter.sv
// tb/tb_sid_access_arbiter.sv - Self-checking bench for sid_access_arbiter

module tb_sid_access_arbiter;

    localparam int DEPTH  = 16;
    localparam int GAP    = 1;
    localparam int PERIOD = 32;

    logic       clk32 = 1'b0;
    logic       reset = 1'b1;
    logic       slot_tick = 1'b0;
    logic       cpu_cs = 1'b0, cpu_we = 1'b0;
    logic [4:0] cpu_addr = '0;
    logic [7:0] cpu_din = '0;
    logic       ext_valid = 1'b0, ext_ready;
    logic [4:0] ext_addr = '0;
    logic [7:0] ext_data = '0;
    logic       ext_flush = 1'b0;
`ifdef SID_ARB_PANIC_EN
    logic       panic = 1'b0;
`endif
    logic       sid_cs, sid_we;
    logic [4:0] sid_addr;
    logic [7:0] sid_din;
    logic [4:0] fifo_level;
    logic       busy;

    sid_access_arbiter #(.FIFO_DEPTH(DEPTH), .MIN_GAP(GAP)) dut (
        .clk32(clk32), .reset(reset), .slot_tick(slot_tick),
        .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_addr(ext_addr),
        .ext_data(ext_data), .ext_flush(ext_flush),
`ifdef SID_ARB_PANIC_EN
        .panic(panic),
`endif
        .sid_cs(sid_cs), .sid_we(sid_we), .sid_addr(sid_addr), .sid_din(sid_din),
        .fifo_level(fifo_level), .busy(busy)
    );

    always #5 clk32 = ~clk32;

    typedef struct packed { logic [4:0] a; logic [7:0] d; } wr_t;

    // Reference model: queued writes in order, ticks elapsed since the last
    // secondary write, and the SID port contents expected after the next edge.
    wr_t        q[$];
    int         ticks_since;
    logic       m_cs, m_we;
    logic [4:0] m_addr;
    logic [7:0] m_din;
    bit         prev_flush;
    int         cyc;
    int         n_cmp, n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ticks_since = GAP;
        m_cs = 0; m_we = 0; m_addr = '0; m_din = '0;
        prev_flush = 0;
    endtask

    // One clk32 cycle. Queue traffic is only offered away from the tick edges so
    // that each queued write is already waiting when its tick arrives.
    task automatic step(input logic c_cs, input logic c_we, input logic [4:0] c_a,
                        input logic [7:0] c_d, input logic e_v, input logic [4:0] e_a,
                        input logic [7:0] e_d, input logic fl);
        int  ph;
        bit  tick, safe, ev, fe, rdy;
        wr_t h;
        ph   = cyc % PERIOD;
        tick = (ph == 0);
        safe = (ph >= 3) && (ph <= 28);
        ev   = e_v && safe;
        fe   = fl && safe;
        slot_tick = tick;
        cpu_cs = c_cs; cpu_we = c_we; cpu_addr = c_a; cpu_din = c_d;
        ext_valid = ev; ext_addr = e_a; ext_data = e_d; ext_flush = fe;
        #1;
        rdy = (q.size() < DEPTH) && !fe;
        if (safe) begin
            check("ext_ready", 32'(ext_ready), 32'(rdy));
            check("fifo_level", 32'(fifo_level), 32'(q.size()));
            if (!prev_flush) check("busy", 32'(busy), 32'(q.size() != 0));
        end
        if (c_cs) begin
            m_cs = 1; m_we = c_we; m_addr = c_a; m_din = c_d;
            if (tick && ticks_since < 15) ticks_since++;
        end else if (tick && q.size() != 0 && ticks_since + 1 >= GAP) begin
            h = q.pop_front();
            m_cs = 1; m_we = 1; m_addr = h.a; m_din = h.d;
            ticks_since = 0;
        end else begin
            m_cs = 0; m_we = 0;
            if (tick && ticks_since < 15) ticks_since++;
        end
        if (ev && rdy) q.push_back({e_a, e_d});
        if (fe) q.delete();
        prev_flush = fe;
        @(posedge clk32);
        cyc++;
        #1;
        check("sid_cs", 32'(sid_cs), 32'(m_cs));
        check("sid_we", 32'(sid_we), 32'(m_we));
        check("sid_addr", 32'(sid_addr), 32'(m_addr));
        check("sid_din", 32'(sid_din), 32'(m_din));
    endtask

    task automatic idle();
        step(0, 0, '0, '0, 0, '0, '0, 0);
    endtask

    task automatic idle_to(input int p);
        while (cyc % PERIOD != p) idle();
    endtask

    task automatic push(input logic [4:0] a, input logic [7:0] d);
        step(0, 0, '0, '0, 1, a, d, 0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        model_reset();
        repeat (2) @(posedge clk32);
        #1;
        check("rst_cs", 32'(sid_cs), 0);
        check("rst_we", 32'(sid_we), 0);
        check("rst_addr", 32'(sid_addr), 0);
        check("rst_din", 32'(sid_din), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 0;

        // CPU passthrough
        idle_to(5);
        step(1, 1, 5'h18, 8'h0F, 0, '0, '0, 0);
        idle();

        // Pacing: four queued writes leave one per tick in push order
        idle_to(4);
        push(5'h00, 8'h11);
        push(5'h01, 8'h22);
        push(5'h04, 8'h21);
        push(5'h05, 8'h09);
        repeat (4 * PERIOD + 8) idle();

        // CPU at the tick defers the queued write; CPU in the issue cycle follows it
        idle_to(4);
        push(5'h02, 8'h33);
        push(5'h03, 8'h44);
        idle_to(0);
        step(1, 1, 5'h07, 8'h55, 0, '0, '0, 0);
        idle_to(0);
        idle();
        step(1, 1, 5'h08, 8'h66, 0, '0, '0, 0);
        idle_to(8);

        // Full, then flush with a refused push in the flush cycle
        idle_to(3);
        for (int i = 0; i < DEPTH + 2; i++) push(5'(i), 8'($urandom));
        step(0, 0, '0, '0, 1, 5'h1F, 8'hAA, 1);
        idle();
        idle();
        repeat (2 * PERIOD) idle();

        // Randomized traffic
        for (int i = 0; i < 2500; i++)
            step($urandom_range(0, 5) == 0, 1'($urandom), 5'($urandom), 8'($urandom),
                 1'($urandom), 5'($urandom), 8'($urandom), $urandom_range(0, 99) == 0);
        idle_to(4);
        repeat (DEPTH * PERIOD + 8) idle();

        // Reset in the middle of a secondary issue with three entries queued
        idle_to(4);
        push(5'h0A, 8'h01);
        push(5'h0B, 8'h02);
        push(5'h0C, 8'h03);
        idle_to(0);
        idle();
        reset = 1;
        #1;
        check("rst_mid_cs", 32'(sid_cs), 0);
        check("rst_mid_we", 32'(sid_we), 0);
        check("rst_mid_level", 32'(fifo_level), 0);
        check("rst_mid_busy", 32'(busy), 0);
        slot_tick = 0; cpu_cs = 0; ext_valid = 0; ext_flush = 0;
        @(posedge clk32);
        @(posedge clk32);
        #1;
        reset = 0;
        model_reset();
        cyc = 1;
        repeat (3 * PERIOD) idle();

`ifdef SID_ARB_PANIC_EN
        begin
            logic [4:0] ga[3];
            logic [7:0] gd[3];
            int         gc[3];
            int         n;
            idle_to(5);
            step(1, 1, 5'h04, 8'h41, 0, '0, '0, 0);
            idle_to(4);
            push(5'h0B, 8'h11);
            idle_to(4);
            push(5'h01, 8'h77);
            push(5'h02, 8'h88);
            idle_to(6);
            panic = 1;
            ext_valid = 0;
            @(posedge clk32);
            cyc++;
            #1;
            panic = 0;
            check("panic_level", 32'(fifo_level), 0);
            check("panic_busy", 32'(busy), 1);
            check("panic_ready", 32'(ext_ready), 0);
            n = 0;
            for (int i = 0; i < 4 * PERIOD; i++) begin
                slot_tick = (cyc % PERIOD == 0);
                @(posedge clk32);
                cyc++;
                #1;
                if (sid_cs && n < 3) begin
                    ga[n] = sid_addr; gd[n] = sid_din; gc[n] = cyc; n++;
                end
            end
            slot_tick = 0;
            check("panic_count", 32'(n), 3);
            if (n == 3) begin
                check("panic_a0", 32'(ga[0]), 32'h04);
                check("panic_d0", 32'(gd[0]), 32'h40);
                check("panic_a1", 32'(ga[1]), 32'h0B);
                check("panic_d1", 32'(gd[1]), 32'h10);
                check("panic_a2", 32'(ga[2]), 32'h12);
                check("panic_d2", 32'(gd[2]), 32'h00);
                check("panic_gap1", 32'(gc[1] - gc[0]), PERIOD);
                check("panic_gap2", 32'(gc[2] - gc[1]), PERIOD);
            end
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
